// File: rtl/agl.sv
// AGL: address generation for paged memory access.
// Holds a 6-bit page captured from pc[15:10] on each rising edge of the
// active-low end-of-instruction strobe, and drives a tri-state address bus
// built from that page (or page zero) and the low ten instruction bits.
module agl (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ir,
    input  logic [15:0] pc,
    input  logic        nread_agl,
    input  logic        nend,
    output logic [15:0] ibus
);

    logic [5:0]  r_page;
    logic        r_nend_d;
    logic        w_nend_rise;
    logic [5:0]  w_page_sel;
    logic [15:0] w_addr;

    // nend is sampled each clock; a low-then-high pair marks the commit point.
    assign w_nend_rise = nend & ~r_nend_d;

    // Page register and strobe history; reset forces the history high so a
    // strobe already high at reset release is not mistaken for a rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_page   <= '0;
            r_nend_d <= 1'b1;
        end else begin
            r_nend_d <= nend;
            if (w_nend_rise) begin
                r_page <= pc[15:10];
            end
        end
    end

    // Address formation: ir[10] selects page zero instead of the held page.
    always_comb begin
        w_page_sel = ir[10] ? 6'b000000 : r_page;
        w_addr     = {w_page_sel, ir[9:0]};
    end

    // Bus is released whenever the read enable is inactive, reset or not.
    assign ibus = nread_agl ? 'z : w_addr;

endmodule

// File: tb/tb_agl.sv
// Self-checking bench for agl. The bus net carries a pull-up so that a
// released bus reads back as all ones in both 4-state and 2-state simulators.
module tb_agl;

    logic        clk;
    logic        reset;
    logic [15:0] ir;
    logic [15:0] pc;
    logic        nread_agl;
    logic        nend;
    tri1  [15:0] ibus;

    int n_checks;
    int n_fail;

    agl u_dut (
        .clk       (clk),
        .reset     (reset),
        .ir        (ir),
        .pc        (pc),
        .nread_agl (nread_agl),
        .nend      (nend),
        .ibus      (ibus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic pulse_nend();
        @(negedge clk) nend = 1'b0;
        @(negedge clk) nend = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; nend = 1'b1; nread_agl = 1'b0; pc = 16'hFC00; ir = 16'h03FC;
        idle(2);
        #1;
        n_checks++;
        if (ibus !== 16'h03FC) begin
            n_fail++;
            $display("FAIL reset_ibus: got %h expected %h", ibus, 16'h03FC);
        end
        ir = 16'h0123; #1;
        n_checks++;
        if (ibus !== 16'h0123) begin
            n_fail++;
            $display("FAIL reset_page_zero: got %h expected %h", ibus, 16'h0123);
        end
        // Held-high nend after release must not capture pc.
        @(negedge clk) reset = 1'b0;
        idle(3);
        ir = 16'h0001; #1;
        n_checks++;
        if (ibus !== 16'h0001) begin
            n_fail++;
            $display("FAIL reset_held_high_no_capture: got %h expected %h", ibus, 16'h0001);
        end
    endtask

    task automatic test_reset_wins();
        @(negedge clk) begin pc = 16'hFC00; nend = 1'b0; end
        @(negedge clk) begin nend = 1'b1; reset = 1'b1; end
        @(negedge clk) reset = 1'b0;
        idle(2);
        ir = 16'h0001; #1;
        n_checks++;
        if (ibus !== 16'h0001) begin
            n_fail++;
            $display("FAIL reset_wins: got %h expected %h", ibus, 16'h0001);
        end
    endtask

    task automatic test_tristate();
        logic [15:0] irs [4] = '{16'h0000, 16'h03FC, 16'h0523, 16'hFFFF};
        nread_agl = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ir = irs[i]; #1;
            n_checks++;
            if (ibus !== 16'hFFFF) begin
                n_fail++;
                $display("FAIL tristate_%0d: got %h expected released (pulled %h)", i, ibus, 16'hFFFF);
            end
        end
        ir = 16'h03FC;
        nread_agl = 1'b0; #1;
        n_checks++;
        if (ibus !== 16'h03FC) begin
            n_fail++;
            $display("FAIL tristate_enable: got %h expected %h", ibus, 16'h03FC);
        end
    endtask

    task automatic test_page_local();
        pc = 16'h4400;
        pulse_nend();
        ir = 16'h0123; #1;
        n_checks++;
        if (ibus !== 16'h4523) begin
            n_fail++;
            $display("FAIL page_local: got %h expected %h", ibus, 16'h4523);
        end
    endtask

    task automatic test_page_zero();
        ir = 16'h0523; #1;
        n_checks++;
        if (ibus !== 16'h0123) begin
            n_fail++;
            $display("FAIL page_zero: got %h expected %h", ibus, 16'h0123);
        end
    endtask

    task automatic test_pc_no_strobe();
        pc = 16'h0400;
        pulse_nend();
        @(negedge clk) pc = 16'hFC00;
        idle(3);
        ir = 16'h0001; #1;
        n_checks++;
        if (ibus !== 16'h0401) begin
            n_fail++;
            $display("FAIL pc_no_strobe_high: got %h expected %h", ibus, 16'h0401);
        end
        // nend held low while pc moves: still no change until it rises.
        @(negedge clk) begin nend = 1'b0; pc = 16'h0800; end
        idle(2);
        @(negedge clk) pc = 16'hFC00;
        idle(2);
        #1;
        n_checks++;
        if (ibus !== 16'h0401) begin
            n_fail++;
            $display("FAIL pc_no_strobe_low: got %h expected %h", ibus, 16'h0401);
        end
        @(negedge clk) nend = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if (ibus !== 16'hFC01) begin
            n_fail++;
            $display("FAIL pc_strobe_commit: got %h expected %h", ibus, 16'hFC01);
        end
    endtask

    task automatic test_upper_ir_ignored();
        logic [15:0] a, b;
        pc = 16'h1400;
        pulse_nend();
        ir = 16'hF805; #1; a = ibus;
        ir = 16'h0005; #1; b = ibus;
        n_checks++;
        if (a !== 16'h1405 || b !== 16'h1405) begin
            n_fail++;
            $display("FAIL upper_ir_ignored: got %h / %h expected %h", a, b, 16'h1405);
        end
    endtask

    task automatic test_sweep();
        logic [15:0] exp_v;
        logic [15:0] irv;
        logic [5:0]  pg;
        int          errs;
        errs = 0;
        for (int unsigned p = 0; p < 64; p++) begin
            pg = p[5:0];
            pc = {pg, 10'b0};
            pulse_nend();
            for (int unsigned v = 16'h03FC; v <= 16'h07FF; v++) begin
                irv = v[15:0];
                ir = irv; #1;
                exp_v = irv[10] ? {6'b000000, irv[9:0]} : {pg, irv[9:0]};
                n_checks++;
                if (ibus !== exp_v) begin
                    n_fail++;
                    errs++;
                    if (errs <= 10)
                        $display("FAIL sweep pc=%h ir=%h: got %h expected %h", pc, irv, ibus, exp_v);
                end
            end
        end
        // Wrap from page 63 back to page 0.
        pc = 16'h0000;
        pulse_nend();
        ir = 16'h03FF; #1;
        n_checks++;
        if (ibus !== 16'h03FF) begin
            n_fail++;
            $display("FAIL sweep_wrap: got %h expected %h", ibus, 16'h03FF);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        reset = 1'b1; nend = 1'b1; nread_agl = 1'b1; ir = '0; pc = '0;
        test_reset();
        test_reset_wins();
        test_tristate();
        test_page_local();
        test_page_zero();
        test_pc_no_strobe();
        test_upper_ir_ignored();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/agl.md
AGL -- requirements
Module: agl

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-high.
REQ-002 Port `clk`: input, 1 bit, system clock; all state updates occur on its rising edge.
REQ-003 Port `reset`: input, 1 bit, synchronous active-high reset.
REQ-004 Port `ir`: input, 16 bits, instruction register; only ir[10:0] is used, ir[15:11] are ignored.
REQ-005 Port `pc`: input, 16 bits, program counter; only pc[15:10] is used.
REQ-006 Port `nread_agl`: input, 1 bit, active-low output enable for `ibus`.
REQ-007 Port `nend`: input, 1 bit, active-low end-of-instruction strobe; its rising edge commits the current page.
REQ-008 Port `ibus`: output, 16 bits, tri-state address bus.

Function
REQ-009 The block SHALL hold a 6-bit page register, PAGE.
REQ-010 The block SHALL hold a 1-bit delayed copy of `nend`, NEND_D, updated every `clk` edge.
REQ-011 On a `clk` edge with reset=0, nend=1 and NEND_D=0 (rising edge of `nend`), PAGE SHALL load pc[15:10].
- Otherwise PAGE SHALL hold.
REQ-012 When `nend` stays high or stays low, PAGE SHALL NOT change, regardless of `pc` activity.
REQ-013 The `ibus` output path SHALL be purely combinational from nread_agl, ir[10:0] and PAGE, with no clock latency.
REQ-014 nread_agl=1: `ibus` SHALL be 16'hZZZZ (all bits high-impedance).
REQ-015 nread_agl=0 and ir[10]=0 (page-local mode): `ibus` SHALL be {PAGE, ir[9:0]}.
REQ-016 nread_agl=0 and ir[10]=1 (page-zero mode): `ibus` SHALL be {6'b000000, ir[9:0]}.
REQ-017 `ibus` SHALL settle within 30 ns of any change on nread_agl, ir or PAGE.
REQ-018 Timing assumptions on `pc`:
- `pc` is stable for at least one `clk` period before and after each `nend` rising edge.
- The `clk` period is at most 20 ns, so PAGE updates within 30 ns of the `nend` rise.
REQ-019 A `pc` change while `nend` is high SHALL have no effect on `ibus` until the next `nend` rising edge.
REQ-020 `nend` rising on the same edge that `reset` is asserted: reset SHALL win.
- PAGE=0 and NEND_D=1.

Reset
REQ-021 While `reset` is high on a `clk` edge, PAGE SHALL become 6'b000000 and NEND_D SHALL become 1.
REQ-022 Reset SHALL NOT affect the tri-state control; `ibus` follows REQ-014 to REQ-016 at all times.
- During and after reset with nread_agl=0 and ir[10]=0, `ibus` SHALL be {6'b0, ir[9:0]}.
REQ-023 The first `nend` rising edge after reset deassertion SHALL be captured only if `nend` was sampled low after reset.
- A held-high `nend` SHALL NOT capture.

Verification
REQ-024 Tri-state:
- nread_agl=1, any ir/pc -> ibus=16'hZZZZ.
- Drop nread_agl to 0 with ir=16'h03FC after reset -> ibus=16'h03FC within 30 ns.
REQ-025 Page-local capture:
- pc=16'h4400, pulse nend low then high -> PAGE=6'b010001.
- ir=16'h0123 -> ibus=16'h4523.
REQ-026 Page-zero: with PAGE=6'b010001 and ir=16'h0523 -> ibus=16'h0123.
REQ-027 PC change without strobe: PAGE=6'b000001, change pc to 16'hFC00 with nend held high, ir=16'h0001 -> ibus stays 16'h0401.
- Then pulse nend -> ibus=16'hFC01.
REQ-028 Upper IR bits ignored: ir=16'hF805 vs ir=16'h0005 with the same PAGE -> identical `ibus`.
REQ-029 Exhaustive sweep:
- ir from 16'h03FC to 16'h07FF.
- pc from 0 to 16'hFC00 in steps of 16'h0400, one nend pulse per pc value.
- Every `ibus` value matches REQ-015/REQ-016 using the pc from the previous nend pulse.
- Includes the wrap from page 6'b111111 back to 6'b000000.
